// File: rtl/risc16_pkg.sv
// Shared definitions for the risc16 CPU: widths, instruction field positions,
// opcodes, ALU operations and the opcode-to-control decoder.
package risc16_pkg;

   localparam int DW   = 16;
   localparam int NREG = 8;
   localparam int SHW  = $clog2(DW);

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RS1_MSB = 11;
   localparam int RS1_LSB = 9;
   localparam int RS2_MSB = 8;
   localparam int RS2_LSB = 6;
   localparam int RD_MSB  = 5;
   localparam int RD_LSB  = 3;
   localparam int OFF_MSB = 5;
   localparam int JA_MSB  = 11;

   localparam logic [3:0] OP_LD  = 4'b0000;
   localparam logic [3:0] OP_ST  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_INV = 4'b0100;
   localparam logic [3:0] OP_LSL = 4'b0101;
   localparam logic [3:0] OP_LSR = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0111;
   localparam logic [3:0] OP_OR  = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1011;
   localparam logic [3:0] OP_BNE = 4'b1100;
   localparam logic [3:0] OP_JMP = 4'b1101;

   // Enum order follows the ALU opcode order, so alu_op = opcode - OP_ADD.
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_INV, ALU_LSL, ALU_LSR, ALU_AND, ALU_OR, ALU_SLT
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_dst;
      logic    alu_src;
      alu_op_e alu_op;
      logic    beq;
      logic    bne;
      logic    jump;
   } ctrl_t;

   function automatic ctrl_t decode(input logic [3:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_LD: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_src    = 1'b1;
         end
         OP_ST: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_SLT: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.alu_op    = alu_op_e'(3'(op - OP_ADD));
         end
         OP_BEQ: begin
            c.beq    = 1'b1;
            c.alu_op = ALU_SUB;
         end
         OP_BNE: begin
            c.bne    = 1'b1;
            c.alu_op = ALU_SUB;
         end
         OP_JMP: c.jump = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/risc16_alu.sv
// risc16 ALU: 16-bit wrapping arithmetic, logic, shifts and unsigned compare.
module risc16_alu
   import risc16_pkg::*;
(
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic [2:0]    op_i,
   output logic [DW-1:0] result_o,
   output logic          zero_o
);

   logic big_shift;

   // Shift counts of DW or more empty the word instead of wrapping the count.
   assign big_shift = (b_i >= DW'(DW));

   always_comb begin
      result_o = '0;
      case (alu_op_e'(op_i))
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_INV: result_o = ~a_i;
         ALU_LSL: result_o = big_shift ? '0 : (a_i << b_i[SHW-1:0]);
         ALU_LSR: result_o = big_shift ? '0 : (a_i >> b_i[SHW-1:0]);
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_SLT: result_o = {{(DW-1){1'b0}}, (a_i < b_i)};
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/risc16.sv
// risc16 top: single-cycle CPU. Memory images are preloaded into
// datapath.im.memory / datapath.dm.memory by the surrounding environment.
module risc16
   import risc16_pkg::*;
#(
   parameter int ROW_I = 16,
   parameter int ROW_D = 8
) (
   input  logic clk,
   input  logic rst
);

   localparam int IAW = $clog2(ROW_I);
   localparam int DAW = $clog2(ROW_D);

   if (1'b1) begin : datapath
      logic [DW-1:0]  pc_current, pc_next, pc_plus1, instr;
      logic [3:0]     opcode;
      logic           beq, bne, jump, branch_control, zero_flag;
      ctrl_t          ctrl;
      logic [2:0]     rs1, rs2, rd, wr_addr;
      logic [DW-1:0]  imm, rd1, rd2, alu_b, alu_result, dm_rdata, wr_data;
      logic [IAW-1:0] im_idx;
      logic [DAW-1:0] dm_idx;

      assign im_idx = IAW'(pc_current % DW'(ROW_I));

      if (1'b1) begin : im
         logic [DW-1:0] memory [ROW_I];
         assign instr = memory[im_idx];
      end

      assign opcode = instr[OP_MSB:OP_LSB];
      assign rs1    = instr[RS1_MSB:RS1_LSB];
      assign rs2    = instr[RS2_MSB:RS2_LSB];
      assign rd     = instr[RD_MSB:RD_LSB];
      assign imm    = {{(DW-OFF_MSB-1){instr[OFF_MSB]}}, instr[OFF_MSB:0]};

      assign ctrl = decode(opcode);
      assign beq  = ctrl.beq;
      assign bne  = ctrl.bne;
      assign jump = ctrl.jump;

      assign wr_addr = ctrl.reg_dst ? rd : rs2;
      assign wr_data = ctrl.mem_to_reg ? dm_rdata : alu_result;

      // Reads are combinational, so an instruction sees pre-edge register values.
      if (1'b1) begin : reg_file
         logic [DW-1:0] reg_array [NREG];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < NREG; i++) reg_array[i] <= '0;
            end else if (ctrl.reg_write) begin
               reg_array[wr_addr] <= wr_data;
            end
         end
         assign rd1 = reg_array[rs1];
         assign rd2 = reg_array[rs2];
      end

      assign alu_b = ctrl.alu_src ? imm : rd2;

      risc16_alu alu (
         .a_i      (rd1),
         .b_i      (alu_b),
         .op_i     (ctrl.alu_op),
         .result_o (alu_result),
         .zero_o   (zero_flag)
      );

      assign dm_idx = DAW'(alu_result % DW'(ROW_D));

      // RAM has no reset; rst only blocks a store landing on the reset edge.
      if (1'b1) begin : dm
         logic [DW-1:0] memory [ROW_D];
         always_ff @(posedge clk) begin
            if (ctrl.mem_write && !rst) memory[dm_idx] <= rd2;
         end
         assign dm_rdata = memory[dm_idx];
      end

      assign pc_plus1       = pc_current + DW'(1);
      assign branch_control = (beq & zero_flag) | (bne & ~zero_flag);
      assign pc_next        = jump ? {pc_plus1[DW-1:JA_MSB+1], instr[JA_MSB:0]}
                            : (branch_control ? (pc_plus1 + imm) : pc_plus1);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) pc_current <= '0;
         else     pc_current <= pc_next;
      end
   end

endmodule

// File: tb/tb_risc16.sv
// Directed-program bench for risc16: expected per-instruction effects are
// queued up front and a clock-driven monitor retires them one per cycle.
module tb_risc16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  risc16 dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] npc;
    logic        jmp;
    logic        br;
    logic        is_mem;
    logic [2:0]  idx;
    logic [15:0] val;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  localparam logic [15:0] PROG1 [16] = '{
    16'h0400, 16'h0441, 16'h2050, 16'h1081, 16'h3050, 16'h4010, 16'h5210, 16'h6050,
    16'h7050, 16'h8050, 16'h9050, 16'h2000, 16'hB085, 16'hC080, 16'hD000, 16'hF000
  };

  localparam logic [15:0] PROG2 [16] = '{
    16'h0400, 16'h2318, 16'h51A8, 16'h03C8, 16'hC33E, 16'hF000, 16'hF000, 16'hF000,
    16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000
  };

  logic [EXP_W-1:0] exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic run     = 1'b0;
  logic busy    = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One entry per instruction: state before the edge and the write it commits.
  task automatic exp_push(input int pc, input int npc, input int jmp, input int br,
                          input int is_mem, input int idx, input logic [15:0] val);
    exp_t e;
    e.pc     = 16'(pc);
    e.npc    = 16'(npc);
    e.jmp    = 1'(jmp);
    e.br     = 1'(br);
    e.is_mem = 1'(is_mem);
    e.idx    = 3'(idx);
    e.val    = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL idle_timeout: %0d entries left, expected 0", exp_q.size());
    end
    run = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (run && exp_q.size() > 0) begin
        busy = 1'b1;
        e = exp_t'(exp_q.pop_front());
        check($sformatf("pc@%0h", e.pc), dut.datapath.pc_current, e.pc);
        check($sformatf("pc_next@%0h", e.pc), dut.datapath.pc_next, e.npc);
        check($sformatf("jump@%0h", e.pc), 16'(dut.datapath.jump), 16'(e.jmp));
        check($sformatf("branch@%0h", e.pc), 16'(dut.datapath.branch_control), 16'(e.br));
        @(posedge clk);
        #1;
        if (e.is_mem)
          check($sformatf("dm[%0d]@%0h", e.idx, e.pc), dut.datapath.dm.memory[e.idx], e.val);
        else
          check($sformatf("r%0d@%0h", e.idx, e.pc), dut.datapath.reg_file.reg_array[e.idx], e.val);
        busy = 1'b0;
      end
    end
  end

  initial begin : stim
    // Phase 1: arithmetic/logic program, branches and jump back to 0.
    for (int i = 0; i < 16; i++) dut.datapath.im.memory[i] = PROG1[i];
    for (int i = 0; i < 8; i++) dut.datapath.dm.memory[i] = 16'h0000;
    dut.datapath.dm.memory[0] = 16'h0001;
    dut.datapath.dm.memory[1] = 16'h0002;

    exp_push( 0,  1, 0, 0, 0, 0, 16'h0001);
    exp_push( 1,  2, 0, 0, 0, 1, 16'h0002);
    exp_push( 2,  3, 0, 0, 0, 2, 16'h0003);
    exp_push( 3,  4, 0, 0, 1, 2, 16'h0003);
    exp_push( 4,  5, 0, 0, 0, 2, 16'hffff);
    exp_push( 5,  6, 0, 0, 0, 2, 16'hfffe);
    exp_push( 6,  7, 0, 0, 0, 2, 16'h0004);
    exp_push( 7,  8, 0, 0, 0, 2, 16'h0000);
    exp_push( 8,  9, 0, 0, 0, 2, 16'h0000);
    exp_push( 9, 10, 0, 0, 0, 2, 16'h0003);
    exp_push(10, 11, 0, 0, 0, 2, 16'h0001);
    exp_push(11, 12, 0, 0, 0, 0, 16'h0002);
    exp_push(12, 13, 0, 0, 0, 2, 16'h0001);
    exp_push(13, 14, 0, 1, 0, 2, 16'h0001);
    exp_push(14,  0, 1, 0, 0, 0, 16'h0002);
    exp_push( 0,  1, 0, 0, 0, 0, 16'h0002);

    repeat (2) @(posedge clk);
    #2;
    check("reset_pc", dut.datapath.pc_current, 16'h0000);
    for (int i = 0; i < 8; i++)
      check($sformatf("reset_r%0d", i), dut.datapath.reg_file.reg_array[i], 16'h0000);
    rst = 1'b0;
    run = 1'b1;
    wait_idle();

    // Mid-run asynchronous reset, checked before any further clock edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pc", dut.datapath.pc_current, 16'h0000);
    check("async_rst_r0", dut.datapath.reg_file.reg_array[0], 16'h0000);

    // Phase 2: preloaded registers, 16-bit shift, address wrap, backward branch.
    for (int i = 0; i < 16; i++) dut.datapath.im.memory[i] = PROG2[i];
    dut.datapath.dm.memory[1] = 16'h7f7f;

    exp_push(0, 1, 0, 0, 0, 0, 16'h7f7f);
    exp_push(1, 2, 0, 0, 0, 3, 16'h1000);
    exp_push(2, 3, 0, 0, 0, 5, 16'h0000);
    exp_push(3, 4, 0, 0, 0, 7, 16'h7f7f);
    exp_push(4, 3, 0, 1, 0, 7, 16'h7f7f);
    exp_push(3, 4, 0, 0, 0, 7, 16'h7f7f);

    @(posedge clk);
    #2;
    rst = 1'b0;
    dut.datapath.reg_file.reg_array[1] = 16'h0001;
    dut.datapath.reg_file.reg_array[2] = 16'h0001;
    dut.datapath.reg_file.reg_array[4] = 16'h0fff;
    dut.datapath.reg_file.reg_array[6] = 16'h0010;
    run = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
